pwm_duty_capture: RTL



---
 rtl/pwm_duty_capture.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_capture.sv
// ---------------------------------------------------------------------------
// pwm_duty_capture
//
// Measures an incoming PWM waveform and reports its high time and its period
// (rising edge to rising edge), both in clk cycles. Used for loop-back
// self-test of the PWM LED driver and for reading external PWM dimming
// commands from a dedicated input pin.
//
// Parameters:
//   CNT_W        width of the high-time/period counters and result registers
//   SYNC_STAGES  number of flops in the pwm_in synchroniser (legal 2..4)
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   enable        measurement enable; low forces the FSM back to IDLE
//   pwm_in        asynchronous PWM input
//   high_cnt      last measured high time, in cycles
//   period_cnt    last measured period, in cycles
//   meas_valid    one-cycle pulse when high_cnt/period_cnt update
//   timeout       one-cycle pulse when a period exceeds the counter range
//   static_level  synchronised pwm_in level captured at the last timeout
//   busy          high while a measurement is in progress (HIGH or LOW)
//
// Optional feature, macro PWM_CAPTURE_DUTY_EN:
//   duty          floor(high_cnt*256/period_cnt), saturated to 255
//   duty_valid    one-cycle pulse 9 cycles after the meas_valid it belongs to
// With the macro undefined these ports and the divider do not exist.
// ---------------------------------------------------------------------------
module pwm_duty_capture #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             timeout,
  output logic             static_level,
  output logic             busy
`ifdef PWM_CAPTURE_DUTY_EN
  ,
  output logic [7:0]       duty,
  output logic             duty_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= pwm_s;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  // -------------------------------------------------------------------------
  // Measurement FSM
  // -------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] pcnt_inc;

  // Both counters saturate at full scale instead of wrapping.
  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
  assign pcnt_inc = (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_ONE;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      hcnt         <= '0;
      pcnt         <= '0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
      static_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      if (!enable) begin
        // Abandon any measurement in progress; results are left untouched
        // and a rise arriving in this same cycle is ignored.
        state <= S_IDLE;
        hcnt  <= '0;
        pcnt  <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (rise) begin
              state <= S_HIGH;
              hcnt  <= CNT_ONE;
              pcnt  <= CNT_ONE;
            end else begin
              hcnt <= '0;
              pcnt <= '0;
            end
          end

          S_HIGH: begin
            // No rise can occur while high, so saturation is always a
            // timeout here; it outranks a coincident fall.
            if (pcnt == CNT_MAX) begin
              timeout      <= 1'b1;
              static_level <= pwm_s;
              state        <= S_IDLE;
              hcnt         <= '0;
              pcnt         <= '0;
            end else if (fall) begin
              // hcnt freezes on the fall cycle; the period keeps counting.
              state <= S_LOW;
              pcnt  <= pcnt_inc;
            end else begin
              hcnt <= hcnt_inc;
              pcnt <= pcnt_inc;
            end
          end

          S_LOW: begin
            // A closing rise wins over saturation, so a period of exactly
            // full scale is still reported as a valid measurement.
            if (rise) begin
              high_cnt   <= hcnt;
              period_cnt <= pcnt;
              meas_valid <= 1'b1;
              state      <= S_HIGH;
              hcnt       <= CNT_ONE;
              pcnt       <= CNT_ONE;
            end else if (pcnt == CNT_MAX) begin
              timeout      <= 1'b1;
              static_level <= pwm_s;
              state        <= S_IDLE;
              hcnt         <= '0;
              pcnt         <= '0;
            end else begin
              pcnt <= pcnt_inc;
            end
          end

          default: begin
            state <= S_IDLE;
            hcnt  <= '0;
            pcnt  <= '0;
          end
        endcase
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  // -------------------------------------------------------------------------
  // Duty-cycle divider: 8-step restoring division of high_cnt*256 by
  // period_cnt, one quotient bit per cycle. The remainder starts at high_cnt,
  // which never exceeds period_cnt; when they are equal every step yields a
  // 1 bit, so the 100% case lands on 255 without a separate clamp.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] div_rem;
  logic [CNT_W-1:0] div_den;
  logic [7:0]       div_quo;
  logic [3:0]       div_left;
  logic [CNT_W:0]   rem_sh;
  logic             rem_ge;

  always_comb begin
    rem_sh = {div_rem, 1'b0};
    rem_ge = (rem_sh >= {1'b0, div_den});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_rem    <= '0;
      div_den    <= '0;
      div_quo    <= '0;
      div_left   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (meas_valid) begin
        // A fresh measurement restarts any division still in flight.
        div_rem  <= high_cnt;
        div_den  <= period_cnt;
        div_quo  <= '0;
        div_left <= 4'd8;
      end else if (div_left != 4'd0) begin
        div_rem  <= CNT_W'(rem_ge ? (rem_sh - {1'b0, div_den}) : rem_sh);
        div_quo  <= {div_quo[6:0], rem_ge};
        div_left <= div_left - 4'd1;
        if (div_left == 4'd1) begin
          duty       <= {div_quo[6:0], rem_ge};
          duty_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule
